master_spi4nano: RTL

SPI master that loads and reads back the Nano system's code ROM and data RAM over the same 4-wire link the on-chip SPI slave serves. It sits on the host/test side, for example in an FPGA harness or a second Tiny Tapeout tile, and turns one-cycle transaction requests into complete chip-select-framed SPI transfers. It returns read data with a done pulse.

---
 rtl/nano_spi_pkg.sv | 52 +++++
 rtl/spi_halfbit_timer.sv | 31 +++
 rtl/master_spi4nano.sv | 135 +++++++++++++
 3 files changed

// File: rtl/nano_spi_pkg.sv
// Shared definitions for the Nano SPI link: command layout, field widths,
// frame lengths, controller state encoding and the frame builder.
package nano_spi_pkg;

  // Command byte bit positions
  localparam int CMD_WR    = 7;
  localparam int CMD_SPACE = 6;

  // Field widths
  localparam int CMD_W     = 8;
  localparam int ADDR_W    = 16;
  localparam int ADDR_IN_W = 12;
  localparam int RAM_DW    = 16;
  localparam int ROM_DW    = 8;

  // Frame lengths in bits
  localparam int N_RAM = CMD_W + ADDR_W + RAM_DW;
  localparam int N_ROM = CMD_W + ADDR_W + ROM_DW;

  // Bit counter width, big enough for N_RAM-1
  localparam int BITCNT_W = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  // Builds the outgoing frame left-aligned in N_RAM bits, so the first bit on
  // the wire is always the MSB. ROM frames are padded with zeros at the bottom
  // and read frames carry zeros in the data field.
  function automatic logic [N_RAM-1:0] build_frame(
    input logic                 rnw,
    input logic                 space,
    input logic [ADDR_IN_W-1:0] addr,
    input logic [RAM_DW-1:0]    wdata
  );
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] a;
    logic [RAM_DW-1:0] d;
    cmd            = '0;
    cmd[CMD_WR]    = ~rnw;
    cmd[CMD_SPACE] = space;
    a              = {4'h0, addr};
    d              = rnw ? '0 : wdata;
    if (space) return {cmd, a, d};
    return {cmd, a, d[ROM_DW-1:0], {ROM_DW{1'b0}}};
  endfunction

endpackage

// File: rtl/spi_halfbit_timer.sv
// Half-period timer: counts 0..H-1, wraps, and flags the last cycle with tick.
// A synchronous clear restarts the count whenever the controller changes state.
module spi_halfbit_timer #(
  parameter int H = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] LAST = CW'(H - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  // Half-period counter with wrap and synchronous clear
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/master_spi4nano.sv
// SPI master (mode 0, MSB first) that turns one-cycle requests into complete
// CS-framed transfers to the Nano code ROM / data RAM slave.
module master_spi4nano
  import nano_spi_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        rnw,
  input  logic        space,
  input  logic [11:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        SPI_CS,
  output logic        SPI_SCK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  localparam int                  H        = CLK_DIV / 2;
  localparam logic [BITCNT_W-1:0] LAST_RAM = BITCNT_W'(N_RAM - 1);
  localparam logic [BITCNT_W-1:0] LAST_ROM = BITCNT_W'(N_ROM - 1);

  state_e              state_q, state_d;
  logic                tick, timer_clr;
  logic                accept, sck_rise, sck_fall, last_low;
  logic                rnw_q, space_q;
  logic [BITCNT_W-1:0] bit_cnt_q;
  logic [N_RAM-1:0]    shift_q;
  logic [RAM_DW-1:0]   rx_q, rdata_q;
  logic                cs_q, cs_d, sck_q, sck_d, busy_q, busy_d, done_q, done_d;

  spi_halfbit_timer #(.H(H)) u_timer (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (timer_clr),
    .tick_o (tick)
  );

  // Timer idles at zero and restarts on every state change
  assign timer_clr = (state_q == IDLE) || (state_d != state_q);

  // A request in the done cycle is refused; it is taken on the next IDLE cycle
  assign accept   = (state_q == IDLE) && start && !done_q;
  // Rising SCK: end of SETUP, or end of a low half that still has bits to send
  assign sck_rise = tick && ((state_q == SETUP) ||
                             ((state_q == SHIFT) && !sck_q && (bit_cnt_q != '0)));
  assign sck_fall = tick && (state_q == SHIFT) && sck_q;
  assign last_low = tick && (state_q == SHIFT) && !sck_q && (bit_cnt_q == '0);

  // State and registered-output flops
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)   state_d = SETUP;
      SETUP:   if (tick)     state_d = SHIFT;
      SHIFT:   if (last_low) state_d = HOLD;
      HOLD:    if (tick)     state_d = GAP;
      GAP:     if (tick)     state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    cs_d   = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    busy_d = (state_d != IDLE);
    done_d = (state_q == GAP) && (state_d == IDLE);
    sck_d  = sck_q;
    if (sck_rise) begin
      sck_d = 1'b1;
    end else if (sck_fall || (state_d != SHIFT)) begin
      sck_d = 1'b0;
    end
  end

  // Datapath: request latch, shift register, bit counter, MISO capture, rdata
  // NOTE: datapath registers are reset too, so MOSI and rdata read zero after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rnw_q     <= 1'b0;
      space_q   <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
    end else if (accept) begin
      rnw_q     <= rnw;
      space_q   <= space;
      shift_q   <= build_frame(rnw, space, addr, wdata);
      bit_cnt_q <= space ? LAST_RAM : LAST_ROM;
    end else begin
      // MOSI advances together with the falling SCK; zeros fill in behind
      if (sck_fall) shift_q <= {shift_q[N_RAM-2:0], 1'b0};
      // MISO is taken on each rising SCK; the last RAM_DW bits are the data field
      if (sck_rise) begin
        rx_q <= {rx_q[RAM_DW-2:0], SPI_MISO};
        if (state_q == SHIFT) bit_cnt_q <= bit_cnt_q - BITCNT_W'(1);
      end
      if (done_d && rnw_q) begin
        rdata_q <= space_q ? rx_q : {{(RAM_DW-ROM_DW){1'b0}}, rx_q[ROM_DW-1:0]};
      end
    end
  end

  assign SPI_CS   = cs_q;
  assign SPI_SCK  = sck_q;
  assign SPI_MOSI = shift_q[N_RAM-1];
  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;

endmodule
